// File: rtl/cell_probe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cell_probe_pkg : shared state encoding and default counter width     |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
package cell_probe_pkg;

  localparam int CNTW_DEFAULT = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RISE = 3'd2,
    S_FALL = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : clear/increment counter that sticks at all-ones        |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] count,
  output logic            last
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

  // High on the edge whose increment would reach the saturation value.
  assign last = (count == (CNT_MAX - CNT_ONE));

endmodule
`default_nettype wire

// File: rtl/cell_delay_probe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cell_delay_probe : drives one cell's D and times its _Q edges        |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module cell_delay_probe
  import cell_probe_pkg::*;
#(
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            U,
  input  logic            RESET,
  input  logic            start,
  output logic            cell_D,
  input  logic            cell_Q,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] tphl_cnt,
  output logic [CNTW-1:0] tplh_cnt,
  output logic            timeout
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state;
  logic            q_hit;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            cnt_last;
  logic [CNTW-1:0] cnt;

  // q_hit: _Q is at the level that ends the current phase (low only in RISE).
  always_comb begin
    q_hit   = (state == S_RISE) ? ~cell_Q : cell_Q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_IDLE:                 cnt_clr = start;
      S_PREP, S_RISE, S_FALL: begin
        if (q_hit) cnt_clr = 1'b1;
        else       cnt_inc = 1'b1;
      end
      default: ;
    endcase
  end

  sat_counter #(.CNTW(CNTW)) u_phase_cnt (
    .clk   (U),
    .rst   (RESET),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge U) begin
    if (RESET) begin
      state    <= S_IDLE;
      cell_D   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      tphl_cnt <= '0;
      tplh_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_PREP;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            tphl_cnt <= '0;
            tplh_cnt <= '0;
          end
        end
        S_PREP: begin
          if (q_hit) begin
            state  <= S_RISE;
            cell_D <= 1'b1;
          end else if (cnt_last) begin
            state   <= S_DONE;
            timeout <= 1'b1;
          end
        end
        S_RISE: begin
          if (q_hit) begin
            tphl_cnt <= cnt + CNT_ONE;
            cell_D   <= 1'b0;
            state    <= S_FALL;
          end else if (cnt_last) begin
            tphl_cnt <= CNT_MAX;
            timeout  <= 1'b1;
            cell_D   <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_FALL: begin
          if (q_hit) begin
            tplh_cnt <= cnt + CNT_ONE;
            state    <= S_DONE;
          end else if (cnt_last) begin
            tplh_cnt <= CNT_MAX;
            timeout  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          cell_D <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cell_delay_probe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cell_delay_probe : cell models, timeline model and directed runs  |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_cell_delay_probe;

  localparam int CNTW       = 6;
  localparam int SAT        = (1 << CNTW) - 1;
  localparam int FALL_FLOPS = 7;
  localparam int RISE_FLOPS = 31;

  localparam int M_COMB   = 0;
  localparam int M_PIPE   = 1;
  localparam int M_STUCK1 = 2;
  localparam int M_STUCK0 = 3;

  logic            U = 1'b0;
  logic            RESET;
  logic            start;
  logic            cell_D;
  logic            cell_Q;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] tphl_cnt;
  logic [CNTW-1:0] tplh_cnt;
  logic            timeout;

  int total = 0;
  int bad   = 0;
  int mode  = M_COMB;

  cell_delay_probe #(.CNTW(CNTW)) dut (
    .U        (U),
    .RESET    (RESET),
    .start    (start),
    .cell_D   (cell_D),
    .cell_Q   (cell_Q),
    .busy     (busy),
    .done     (done),
    .tphl_cnt (tphl_cnt),
    .tplh_cnt (tplh_cnt),
    .timeout  (timeout)
  );

  always #5 U = ~U;

  // Asymmetric cell: D must hold high FALL_FLOPS edges to pull _Q low,
  // and hold low RISE_FLOPS edges to release it.
  logic pr     = 1'b0;
  logic last_d = 1'b0;
  int   run    = 100;
  int   run_nxt;
  assign run_nxt = (cell_D == last_d) ? ((run < 1000) ? run + 1 : run) : 1;

  always @(posedge U) begin
    last_d <= cell_D;
    run    <= run_nxt;
    if (cell_D && run_nxt >= FALL_FLOPS) pr <= 1'b1;
    if (!cell_D && run_nxt >= RISE_FLOPS) pr <= 1'b0;
  end

  always_comb begin
    cell_Q = 1'b1;
    case (mode)
      M_COMB:   cell_Q = ~cell_D;
      M_PIPE:   cell_Q = ~pr;
      M_STUCK1: cell_Q = 1'b1;
      M_STUCK0: cell_Q = 1'b0;
      default:  cell_Q = 1'b1;
    endcase
  end

  // Timeline model: k counts edges since the accepting edge (k=0).
  // A run lasts pw + hl + lh + 2 edges; done is seen after the last one.
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  int   m_k = 0, m_hl = 0, m_lh = 0, m_to = 0;
  int   p_pw = 1, p_hl = 0, p_lh = 0, p_to = 0;

  always @(posedge U) begin
    if (RESET) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_hl <= 0; m_lh <= 0; m_to <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_k <= m_k + 1;
        if (m_k + 1 == p_pw + p_hl + p_lh + 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_hl <= p_hl; m_lh <= p_lh; m_to <= p_to;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_k <= 0;
        m_hl <= 0; m_lh <= 0; m_to <= 0;
        case (mode)
          M_COMB:   begin p_pw <= 1;   p_hl <= 1;              p_lh <= 1;              p_to <= 0; end
          M_PIPE:   begin p_pw <= 1;   p_hl <= FALL_FLOPS + 1; p_lh <= RISE_FLOPS + 1; p_to <= 0; end
          M_STUCK1: begin p_pw <= 1;   p_hl <= SAT;            p_lh <= 0;              p_to <= 1; end
          default:  begin p_pw <= SAT; p_hl <= 0;              p_lh <= 0;              p_to <= 1; end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge U) begin
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("cell_D", cell_D, m_active && m_k >= p_pw && m_k < p_pw + p_hl);
    if (!m_active || m_k == 0) begin
      chk("tphl_cnt", tphl_cnt, m_hl);
      chk("tplh_cnt", tplh_cnt, m_lh);
      chk("timeout", timeout, m_to);
    end
  end

  // Pulses start for one edge and measures edges-to-done and busy cycles.
  task automatic run_meas(input int md, output int lat, output int bcnt);
    mode  = md;
    start = 1'b1;
    @(negedge U);
    start = 1'b0;
    lat   = 1;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(negedge U);
      lat++;
      if (busy) bcnt++;
    end
    if (!done) chk("done_wait", 0, 1);
  endtask

  int lat, bcnt, ndone, cyc, prev;

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge U);
    chk("rst_cell_D", cell_D, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tphl", tphl_cnt, 0);
    chk("rst_timeout", timeout, 0);
    RESET = 1'b0;
    @(negedge U);

    run_meas(M_COMB, lat, bcnt);
    chk("comb_tphl", tphl_cnt, 1);
    chk("comb_tplh", tplh_cnt, 1);
    chk("comb_timeout", timeout, 0);
    chk("comb_latency", lat, 5);
    chk("comb_busy_cycles", bcnt, 4);
    repeat (2) @(negedge U);

    run_meas(M_PIPE, lat, bcnt);
    chk("pipe_tphl", tphl_cnt, 8);
    chk("pipe_tplh", tplh_cnt, 32);
    chk("pipe_timeout", timeout, 0);
    chk("pipe_latency", lat, 43);
    repeat (2) @(negedge U);

    run_meas(M_STUCK1, lat, bcnt);
    chk("stuck1_tphl", tphl_cnt, 63);
    chk("stuck1_tplh", tplh_cnt, 0);
    chk("stuck1_timeout", timeout, 1);
    chk("stuck1_latency", lat, 66);
    @(negedge U);
    chk("stuck1_cell_D", cell_D, 0);
    @(negedge U);

    run_meas(M_STUCK0, lat, bcnt);
    chk("stuck0_tphl", tphl_cnt, 0);
    chk("stuck0_tplh", tplh_cnt, 0);
    chk("stuck0_timeout", timeout, 1);
    chk("stuck0_latency", lat, 65);
    @(negedge U);
    chk("stuck0_single_done", done, 0);

    // start held high: back-to-back runs, timeout cleared at the first accept
    mode  = M_COMB;
    start = 1'b1;
    ndone = 0; cyc = 0; prev = 0;
    while (ndone < 3 && cyc < 100) begin
      @(negedge U);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone > 1) chk("b2b_period", cyc - prev, 5);
        prev = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_runs", ndone, 3);
    chk("b2b_first_done", prev - 10, 5);
    repeat (2) @(negedge U);

    // reset mid-RISE, then a clean measurement
    mode  = M_PIPE;
    start = 1'b1;
    @(negedge U);
    start = 1'b0;
    repeat (3) @(negedge U);
    chk("midrise_cell_D", cell_D, 1);
    RESET = 1'b1;
    @(negedge U);
    chk("rst_mid_cell_D", cell_D, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tphl", tphl_cnt, 0);
    chk("rst_mid_tplh", tplh_cnt, 0);
    RESET = 1'b0;
    @(negedge U);
    run_meas(M_PIPE, lat, bcnt);
    chk("post_rst_tphl", tphl_cnt, 8);
    chk("post_rst_tplh", tplh_cnt, 32);
    chk("post_rst_timeout", timeout, 0);
    repeat (3) @(negedge U);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
